bcd_display_sequencer: RTL and testbench

Sequences iterative binary-to-BCD conversion for the board's 7-segment readouts. It time-shares one shift-and-add-3 (double-dabble) engine between two requesters, the program counter and a data value. It produces stable, atomically updated 4-digit BCD words that feed the `display_7segmentos` decoders. It sits between the CPU datapath outputs and the display decoders, and removes the divide/modulo logic from the display path.

---
 rtl/display_pkg.sv | 21 ++
 rtl/double_dabble_core.sv | 49 ++++
 rtl/bcd_display_sequencer.sv | 118 +++++++++++
 tb/tb_bcd_display_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the BCD display path: sequencer states, default
// operand/digit sizes and the double-dabble digit correction.
package display_pkg;

    localparam int unsigned defaultWidth  = 11;
    localparam int unsigned defaultDigits = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StStore
    } seqState_t;

    // A digit of 5 or more would exceed 9 after the next doubling, so it is
    // pre-biased by 3 to carry into the next digit instead.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/double_dabble_core.sv
// Shift-and-add-3 engine: one {BCD, binary} shift register plus the step counter.
// The sequencer loads an operand, steps it WIDTH times, then reads bcd.
module double_dabble_core
    import display_pkg::*;
#(
    parameter int unsigned WIDTH  = defaultWidth,
    parameter int unsigned DIGITS = defaultDigits
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH-1:0]      operand,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  last_step
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [BcdW+WIDTH-1:0] shiftReg;
    logic [BcdW-1:0]       corrected;
    logic [CntW-1:0]       stepCount;

    always_comb begin
        corrected = '0;
        for (int d = 0; d < DIGITS; d++) begin
            corrected[4*d +: 4] = add3_if_ge5(shiftReg[WIDTH + 4*d +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shiftReg  <= '0;
            stepCount <= '0;
        end else if (load) begin
            shiftReg  <= {{BcdW{1'b0}}, operand};
            stepCount <= '0;
        end else if (step) begin
            shiftReg  <= {corrected, shiftReg[WIDTH-1:0]} << 1;
            stepCount <= stepCount + CntW'(1);
        end
    end

    assign bcd       = shiftReg[BcdW+WIDTH-1 -: BcdW];
    // Valid while stepping: the step taken on this edge is the final one.
    assign last_step = (stepCount == CntW'(WIDTH - 1));

endmodule

// File: rtl/bcd_display_sequencer.sv
// Time-shares one double-dabble core between PC and Dado, publishing each
// 4-digit BCD word atomically in its own STORE cycle.
module bcd_display_sequencer
    import display_pkg::*;
#(
    parameter int unsigned WIDTH  = defaultWidth,
    parameter int unsigned DIGITS = defaultDigits
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      PC,
    input  logic [WIDTH-1:0]      Dado,
    input  logic                  refresh,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   PC_BCD,
    output logic [4*DIGITS-1:0]   Dado_BCD
);

    seqState_t             stateQ, stateD;
    logic                  srcQ, srcD;
    logic                  pendingQ, pendingD;
    logic                  doneQ, doneD;
    logic [4*DIGITS-1:0]   pcBcdQ, pcBcdD;
    logic [4*DIGITS-1:0]   dadoBcdQ, dadoBcdD;

    logic                  coreLoad, coreStep, coreLast;
    logic [WIDTH-1:0]      coreOperand;
    logic [4*DIGITS-1:0]   coreBcd;

    assign coreOperand = srcQ ? Dado : PC;

    double_dabble_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (coreLoad),
        .step      (coreStep),
        .operand   (coreOperand),
        .bcd       (coreBcd),
        .last_step (coreLast)
    );

    always_comb begin
        stateD   = stateQ;
        srcD     = srcQ;
        pendingD = pendingQ;
        doneD    = 1'b0;
        pcBcdD   = pcBcdQ;
        dadoBcdD = dadoBcdQ;
        coreLoad = 1'b0;
        coreStep = 1'b0;

        if (stateQ != StIdle && refresh) begin
            pendingD = 1'b1;
        end

        unique case (stateQ)
            StIdle: begin
                if (refresh) begin
                    stateD = StLoad;
                    srcD   = 1'b0;
                end
            end
            StLoad: begin
                coreLoad = 1'b1;
                stateD   = StShift;
            end
            StShift: begin
                coreStep = 1'b1;
                if (coreLast) begin
                    stateD = StStore;
                end
            end
            StStore: begin
                if (!srcQ) begin
                    pcBcdD = coreBcd;
                    srcD   = 1'b1;
                    stateD = StLoad;
                end else begin
                    dadoBcdD = coreBcd;
                    doneD    = 1'b1;
                    srcD     = 1'b0;
                    pendingD = 1'b0;
                    // A request arriving on this very edge still earns a sweep.
                    stateD   = (pendingQ || refresh) ? StLoad : StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ   <= StIdle;
            srcQ     <= 1'b0;
            pendingQ <= 1'b0;
            doneQ    <= 1'b0;
            pcBcdQ   <= '0;
            dadoBcdQ <= '0;
        end else begin
            stateQ   <= stateD;
            srcQ     <= srcD;
            pendingQ <= pendingD;
            doneQ    <= doneD;
            pcBcdQ   <= pcBcdD;
            dadoBcdQ <= dadoBcdD;
        end
    end

    assign busy     = (stateQ != StIdle);
    assign done     = doneQ;
    assign PC_BCD   = pcBcdQ;
    assign Dado_BCD = dadoBcdQ;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed bench for bcd_display_sequencer: a scoreboard queue of expected BCD
// words is filled as sweeps are requested and drained as results appear.
module tb_bcd_display_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] dado;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] PC    = '0;
    logic [10:0] Dado  = '0;
    logic        refresh = 1'b0;
    logic        busy, done;
    logic [15:0] PC_BCD, Dado_BCD;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bcd_display_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .PC       (PC),
        .Dado     (Dado),
        .refresh  (refresh),
        .busy     (busy),
        .done     (done),
        .PC_BCD   (PC_BCD),
        .Dado_BCD (Dado_BCD)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] toBcd(input int unsigned v);
        logic [15:0] r;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep from IDLE; optionally changes PC before edge changeAt.
    task automatic runSweep(input int unsigned pc, input int unsigned dado,
                            input int changeAt, input int unsigned changeVal);
        int   busyCnt;
        logic early;
        exp_t e;
        PC   = 11'(pc);
        Dado = 11'(dado);
        sb.push_back({toBcd(pc), toBcd(dado)});
        refresh = 1'b1;
        tick;                                   // E0
        refresh = 1'b0;
        busyCnt = int'(busy);
        early   = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            if (i == changeAt) PC = 11'(changeVal);
            tick;
            busyCnt += int'(busy);
            if (i == 13) begin
                if (sb.size() > 0) check("pc_bcd_e13", PC_BCD, sb[0].pc);
                else check("sb_nonempty_e13", 0, 1);
            end
            if (i < 26 && done) early = 1'b1;
        end
        check("done_e26", done, 1);
        check("busy_after_e26", busy, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dado_bcd_e26", Dado_BCD, e.dado);
            check("pc_bcd_held", PC_BCD, e.pc);
        end else begin
            check("sb_nonempty_e26", 0, 1);
        end
        check("busy_cycles", busyCnt, 26);
        check("done_early", early, 0);
        tick;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic sawBusy, sawDone, earlyDone;
        int   busyCnt;
        exp_t e;

        // Reset, then a long idle stretch.
        repeat (3) tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", PC_BCD, 0);
        check("rst_dado", Dado_BCD, 0);
        sawBusy = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            sawBusy |= busy;
            sawDone |= done;
        end
        check("idle_busy", sawBusy, 0);
        check("idle_done", sawDone, 0);
        check("idle_pc", PC_BCD, 0);
        check("idle_dado", Dado_BCD, 0);

        // Main function and boundaries.
        runSweep(1234, 2047, -1, 0);
        runSweep(0, 9, -1, 0);
        runSweep(10, 999, -1, 0);

        // Snapshot: PC changes mid-shift; the next sweep sees the new value.
        runSweep(5, 3, 3, 77);
        runSweep(77, 3, -1, 0);

        // Pending: refresh at E5 and E20 queues exactly one back-to-back sweep.
        PC   = 11'd321;
        Dado = 11'd654;
        sb.push_back({toBcd(321), toBcd(654)});
        refresh = 1'b1;
        tick;                                   // E0
        refresh = 1'b0;
        busyCnt   = int'(busy);
        earlyDone = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            refresh = (i == 5 || i == 20);
            tick;
            refresh = 1'b0;
            if (i < 52) busyCnt += int'(busy);
            if (i == 14) begin
                // Dado captured at E14; both operands for the queued sweep change now.
                PC   = 11'd1999;
                Dado = 11'd88;
                sb.push_back({toBcd(1999), toBcd(88)});
            end
            if (i == 13 || i == 39) begin
                if (sb.size() > 0) check("pend_pc_bcd", PC_BCD, sb[0].pc);
                else check("pend_sb_nonempty", 0, 1);
            end
            if (i == 26 || i == 52) begin
                check("pend_done", done, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pend_dado_bcd", Dado_BCD, e.dado);
                end else begin
                    check("pend_sb_nonempty", 0, 1);
                end
            end else if (done) begin
                earlyDone = 1'b1;
            end
        end
        check("pend_busy_continuous", busyCnt, 52);
        check("pend_no_stray_done", earlyDone, 0);
        check("pend_idle_after", busy, 0);
        sawBusy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            sawBusy |= busy;
        end
        check("pend_no_third_sweep", sawBusy, 0);

        // Reset mid-sweep at E10.
        PC   = 11'd600;
        Dado = 11'd700;
        refresh = 1'b1;
        tick;                                   // E0
        refresh = 1'b0;
        repeat (9) tick;                        // through E9
        reset = 1'b1;
        tick;                                   // E10
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pc", PC_BCD, 0);
        check("mid_rst_dado", Dado_BCD, 0);
        sawBusy = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            sawBusy |= busy;
            sawDone |= done;
        end
        check("mid_rst_no_done", sawDone, 0);
        check("mid_rst_stays_idle", sawBusy, 0);
        runSweep(42, 1500, -1, 0);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
